// File: rtl/pipeline_mem_pkg.sv
// Shared encodings for the MEM stage: load/store controls, access sizes and FSM states.
package pipeline_mem_pkg;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LB   = 3'd1;
    localparam logic [2:0] RD_LBU  = 3'd2;
    localparam logic [2:0] RD_LH   = 3'd3;
    localparam logic [2:0] RD_LHU  = 3'd4;
    localparam logic [2:0] RD_LW   = 3'd5;
    localparam logic [2:0] RD_LWU  = 3'd6;
    localparam logic [2:0] RD_LD   = 3'd7;

    localparam logic [2:0] WR_NONE = 3'd0;
    localparam logic [2:0] WR_SB   = 3'd1;
    localparam logic [2:0] WR_SH   = 3'd2;
    localparam logic [2:0] WR_SW   = 3'd3;
    localparam logic [2:0] WR_SD   = 3'd4;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    typedef enum logic {ST_IDLE, ST_REQ} state_e;

    function automatic logic [7:0] size_mask(size_e sz);
        case (sz)
            SZ_H:    return MASK_H;
            SZ_W:    return MASK_W;
            SZ_D:    return MASK_D;
            default: return MASK_B;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational load/store alignment: access decode, misalign detect, strobe/data lane
// build for stores and extract/extend for loads.
module mem_lsu_align
    import pipeline_mem_pkg::*;
(
    input  logic [2:0]  rd_ctrl,
    input  logic [2:0]  wr_ctrl,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] st_data,
    input  logic [63:0] ld_raw,
    output logic        is_load,
    output logic        is_store,
    output logic        misalign,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata,
    output logic [63:0] ld_data
);

    size_e       size;
    logic [63:0] ld_shift;

    always_comb begin
        is_store = (wr_ctrl >= WR_SB) && (wr_ctrl <= WR_SD);
        // A valid store overrides any read control presented alongside it
        is_load  = (rd_ctrl != RD_NONE) && !is_store;

        size = SZ_B;
        if (is_store) begin
            case (wr_ctrl)
                WR_SH:   size = SZ_H;
                WR_SW:   size = SZ_W;
                WR_SD:   size = SZ_D;
                default: size = SZ_B;
            endcase
        end else if (is_load) begin
            case (rd_ctrl)
                RD_LH, RD_LHU: size = SZ_H;
                RD_LW, RD_LWU: size = SZ_W;
                RD_LD:         size = SZ_D;
                default:       size = SZ_B;
            endcase
        end

        case (size)
            SZ_H:    misalign = addr_lo[0];
            SZ_W:    misalign = |addr_lo[1:0];
            SZ_D:    misalign = |addr_lo;
            default: misalign = 1'b0;
        endcase

        wstrb = size_mask(size) << addr_lo;

        case (size)
            SZ_H:    wdata = {4{st_data[15:0]}};
            SZ_W:    wdata = {2{st_data[31:0]}};
            SZ_D:    wdata = st_data;
            default: wdata = {8{st_data[7:0]}};
        endcase

        ld_shift = ld_raw >> {addr_lo, 3'b000};
        ld_data  = 64'd0;
        if (is_load) begin
            case (rd_ctrl)
                RD_LB:   ld_data = {{56{ld_shift[7]}},  ld_shift[7:0]};
                RD_LBU:  ld_data = {56'd0,              ld_shift[7:0]};
                RD_LH:   ld_data = {{48{ld_shift[15]}}, ld_shift[15:0]};
                RD_LHU:  ld_data = {48'd0,              ld_shift[15:0]};
                RD_LW:   ld_data = {{32{ld_shift[31]}}, ld_shift[31:0]};
                RD_LWU:  ld_data = {32'd0,              ld_shift[31:0]};
                default: ld_data = ld_shift;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_mem_stage7.sv
// MEM pipeline stage: two-state request FSM toward the data memory and the registered
// MEM/WB boundary. Upstream is stalled through mem_busy while a request is outstanding.
module pipeline_mem_stage7
    import pipeline_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_EXC,
    input  logic        rf_wr_en_EXC,
    input  logic [1:0]  rf_wr_sel_EXC,
    input  logic [63:0] alu_result_EXC,
    input  logic [2:0]  dm_rd_ctrl_EXC,
    input  logic [2:0]  dm_wr_ctrl_EXC,
    input  logic [63:0] reg_data2_EXC,
    input  logic [4:0]  rd_EXC,
    output logic        dm_req,
    output logic        dm_we,
    output logic [63:0] dm_addr,
    output logic [7:0]  dm_wstrb,
    output logic [63:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [63:0] dm_rdata,
    output logic        mem_busy,
    output logic [63:0] pc_WB,
    output logic        rf_wr_en_WB,
    output logic [1:0]  rf_wr_sel_WB,
    output logic [63:0] alu_result_WB,
    output logic [63:0] dm_data_WB,
    output logic [4:0]  rd_WB,
    output logic        misalign_WB
);

    logic        is_load, is_store, misalign;
    logic [63:0] ld_data;

    state_e      state_q, state_d;
    logic [63:0] pc_wb_q, pc_wb_d;
    logic        rf_wr_en_wb_q, rf_wr_en_wb_d;
    logic [1:0]  rf_wr_sel_wb_q, rf_wr_sel_wb_d;
    logic [63:0] alu_result_wb_q, alu_result_wb_d;
    logic [63:0] dm_data_wb_q, dm_data_wb_d;
    logic [4:0]  rd_wb_q, rd_wb_d;
    logic        misalign_wb_q, misalign_wb_d;

    mem_lsu_align u_align (
        .rd_ctrl  (dm_rd_ctrl_EXC),
        .wr_ctrl  (dm_wr_ctrl_EXC),
        .addr_lo  (alu_result_EXC[2:0]),
        .st_data  (reg_data2_EXC),
        .ld_raw   (dm_rdata),
        .is_load  (is_load),
        .is_store (is_store),
        .misalign (misalign),
        .wstrb    (dm_wstrb),
        .wdata    (dm_wdata),
        .ld_data  (ld_data)
    );

    // EXC inputs are frozen by mem_busy, so the request fields stay stable through REQ
    assign dm_req  = (state_q == ST_REQ);
    assign dm_we   = dm_req && is_store;
    assign dm_addr = {alu_result_EXC[63:3], 3'b000};

    always_comb begin
        state_d  = state_q;
        mem_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((is_load || is_store) && !misalign) begin
                    mem_busy = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_busy = !dm_ready;
                if (dm_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        pc_wb_d         = pc_EXC;
        rf_wr_sel_wb_d  = rf_wr_sel_EXC;
        alu_result_wb_d = alu_result_EXC;
        rd_wb_d         = rd_EXC;
        // Stalled cycles pass a bubble: nothing may be written back twice
        rf_wr_en_wb_d   = rf_wr_en_EXC && !misalign && !mem_busy;
        misalign_wb_d   = misalign && !mem_busy;
        dm_data_wb_d    = (is_load && !misalign && !mem_busy) ? ld_data : 64'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            pc_wb_q         <= 64'd0;
            rf_wr_en_wb_q   <= 1'b0;
            rf_wr_sel_wb_q  <= 2'd0;
            alu_result_wb_q <= 64'd0;
            dm_data_wb_q    <= 64'd0;
            rd_wb_q         <= 5'd0;
            misalign_wb_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_wb_q         <= pc_wb_d;
            rf_wr_en_wb_q   <= rf_wr_en_wb_d;
            rf_wr_sel_wb_q  <= rf_wr_sel_wb_d;
            alu_result_wb_q <= alu_result_wb_d;
            dm_data_wb_q    <= dm_data_wb_d;
            rd_wb_q         <= rd_wb_d;
            misalign_wb_q   <= misalign_wb_d;
        end
    end

    assign pc_WB         = pc_wb_q;
    assign rf_wr_en_WB   = rf_wr_en_wb_q;
    assign rf_wr_sel_WB  = rf_wr_sel_wb_q;
    assign alu_result_WB = alu_result_wb_q;
    assign dm_data_WB    = dm_data_wb_q;
    assign rd_WB         = rd_wb_q;
    assign misalign_WB   = misalign_wb_q;

endmodule

// File: tb/tb_pipeline_mem_stage7.sv
// Directed bench for the MEM stage: a vector table of single ops plus hand-written
// stall, back-to-back and reset-during-request sequences.
module tb_pipeline_mem_stage7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pc_EXC = '0;
    logic        rf_wr_en_EXC = 1'b0;
    logic [1:0]  rf_wr_sel_EXC = '0;
    logic [63:0] alu_result_EXC = '0;
    logic [2:0]  dm_rd_ctrl_EXC = '0;
    logic [2:0]  dm_wr_ctrl_EXC = '0;
    logic [63:0] reg_data2_EXC = '0;
    logic [4:0]  rd_EXC = '0;
    logic        dm_req, dm_we;
    logic [63:0] dm_addr, dm_wdata;
    logic [7:0]  dm_wstrb;
    logic        dm_ready = 1'b0;
    logic [63:0] dm_rdata = '0;
    logic        mem_busy;
    logic [63:0] pc_WB, alu_result_WB, dm_data_WB;
    logic        rf_wr_en_WB, misalign_WB;
    logic [1:0]  rf_wr_sel_WB;
    logic [4:0]  rd_WB;

    int checks = 0;
    int failures = 0;

    pipeline_mem_stage7 dut (
        .clk(clk), .reset(reset),
        .pc_EXC(pc_EXC), .rf_wr_en_EXC(rf_wr_en_EXC), .rf_wr_sel_EXC(rf_wr_sel_EXC),
        .alu_result_EXC(alu_result_EXC), .dm_rd_ctrl_EXC(dm_rd_ctrl_EXC),
        .dm_wr_ctrl_EXC(dm_wr_ctrl_EXC), .reg_data2_EXC(reg_data2_EXC), .rd_EXC(rd_EXC),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_busy(mem_busy),
        .pc_WB(pc_WB), .rf_wr_en_WB(rf_wr_en_WB), .rf_wr_sel_WB(rf_wr_sel_WB),
        .alu_result_WB(alu_result_WB), .dm_data_WB(dm_data_WB), .rd_WB(rd_WB),
        .misalign_WB(misalign_WB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=0x%h exp=0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] pc, input logic wr_en, input logic [1:0] sel,
                         input logic [63:0] addr, input logic [2:0] rdc, input logic [2:0] wrc,
                         input logic [63:0] d2, input logic [4:0] rd);
        pc_EXC = pc; rf_wr_en_EXC = wr_en; rf_wr_sel_EXC = sel; alu_result_EXC = addr;
        dm_rd_ctrl_EXC = rdc; dm_wr_ctrl_EXC = wrc; reg_data2_EXC = d2; rd_EXC = rd;
    endtask

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic        wr_en;
        logic [1:0]  sel;
        logic [63:0] addr;
        logic [2:0]  rdc;
        logic [2:0]  wrc;
        logic [63:0] d2;
        logic [4:0]  rd;
        logic [63:0] rdata;
        int          busy;
        logic        we;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        logic        mis;
        logic        wb_wr_en;
        logic [63:0] dm_data;
    } vec_t;

    vec_t vecs[16];

    task automatic run_vec(input vec_t v);
        int  busy_cnt = 0;
        int  req_cnt = 0;
        bit  done = 0;
        drive(v.pc, v.wr_en, v.sel, v.addr, v.rdc, v.wrc, v.d2, v.rd);
        dm_rdata = v.rdata;
        dm_ready = 1'b1;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (dm_req) begin
                req_cnt++;
                chk({v.name, ".dm_addr"}, dm_addr, {v.addr[63:3], 3'b000});
                chk({v.name, ".dm_we"}, 64'(dm_we), 64'(v.we));
                if (v.we) begin
                    chk({v.name, ".dm_wstrb"}, 64'(dm_wstrb), 64'(v.wstrb));
                    chk({v.name, ".dm_wdata"}, dm_wdata, v.wdata);
                end
            end
            if (!mem_busy) done = 1;
            else busy_cnt++;
            @(posedge clk); #1;
        end
        chk({v.name, ".completed"}, 64'(done), 64'd1);
        chk({v.name, ".busy_cycles"}, 64'(busy_cnt), 64'(v.busy));
        chk({v.name, ".req_cycles"}, 64'(req_cnt), 64'(v.busy));
        chk({v.name, ".pc_WB"}, pc_WB, v.pc);
        chk({v.name, ".rf_wr_en_WB"}, 64'(rf_wr_en_WB), 64'(v.wb_wr_en));
        chk({v.name, ".rf_wr_sel_WB"}, 64'(rf_wr_sel_WB), 64'(v.sel));
        chk({v.name, ".alu_result_WB"}, alu_result_WB, v.addr);
        chk({v.name, ".rd_WB"}, 64'(rd_WB), 64'(v.rd));
        chk({v.name, ".misalign_WB"}, 64'(misalign_WB), 64'(v.mis));
        chk({v.name, ".dm_data_WB"}, dm_data_WB, v.dm_data);
        $display("txn %s busy=%0d wb_data=0x%h", v.name, busy_cnt, dm_data_WB);
    endtask

    initial begin
        int busy_cnt;
        int req_cnt;
        int writes;

        //        name        pc      we sel addr     rdc wrc d2                     rd rdata                  busy we  wstrb  wdata                  mis wbwe dm_data
        vecs[0]  = '{"add",     64'h100,1,0,64'hAAAA, 0,0,64'h0,                 5, 64'h0,                 0,0,8'h00,64'h0,                 0,1,64'h0};
        vecs[1]  = '{"lb",      64'h104,1,1,64'h1003, 1,0,64'h0,                 6, 64'h00000000_80000000, 1,0,8'h00,64'h0,                 0,1,64'hFFFFFFFF_FFFFFF80};
        vecs[2]  = '{"sh",      64'h108,0,0,64'h2006, 0,2,64'h1234,              0, 64'h0,                 1,1,8'hC0,64'h12341234_12341234, 0,0,64'h0};
        vecs[3]  = '{"lw_mis",  64'h10C,1,1,64'h4002, 5,0,64'h0,                 7, 64'h0,                 0,0,8'h00,64'h0,                 1,0,64'h0};
        vecs[4]  = '{"lhu",     64'h110,1,1,64'h6002, 4,0,64'h0,                 8, 64'h00000000_80010000, 1,0,8'h00,64'h0,                 0,1,64'h8001};
        vecs[5]  = '{"lh",      64'h114,1,1,64'h6002, 3,0,64'h0,                 9, 64'h00000000_80010000, 1,0,8'h00,64'h0,                 0,1,64'hFFFFFFFF_FFFF8001};
        vecs[6]  = '{"sb",      64'h118,0,0,64'h7005, 0,1,64'hAB,                0, 64'h0,                 1,1,8'h20,64'hABABABAB_ABABABAB, 0,0,64'h0};
        vecs[7]  = '{"sw",      64'h11C,0,0,64'h8004, 0,3,64'h11223344_CAFEF00D, 0, 64'h0,                 1,1,8'hF0,64'hCAFEF00D_CAFEF00D, 0,0,64'h0};
        vecs[8]  = '{"sd",      64'h120,0,0,64'h9000, 0,4,64'h01234567_89ABCDEF, 0, 64'h0,                 1,1,8'hFF,64'h01234567_89ABCDEF, 0,0,64'h0};
        vecs[9]  = '{"sd_mis",  64'h124,0,0,64'h9004, 0,4,64'h0,                 0, 64'h0,                 0,0,8'h00,64'h0,                 1,0,64'h0};
        vecs[10] = '{"lbu_b7",  64'h128,1,1,64'hA007, 2,0,64'h0,                 10,64'hFE000000_00000000, 1,0,8'h00,64'h0,                 0,1,64'hFE};
        vecs[11] = '{"st_wins", 64'h12C,0,0,64'hB001, 7,1,64'h5A,                0, 64'hFFFFFFFF_FFFFFFFF, 1,1,8'h02,64'h5A5A5A5A_5A5A5A5A, 0,0,64'h0};
        vecs[12] = '{"wr_rsv",  64'h130,1,2,64'hC003, 0,5,64'hFFFF,              11,64'h0,                 0,0,8'h00,64'h0,                 0,1,64'h0};
        vecs[13] = '{"ld",      64'h134,1,1,64'hC000, 7,0,64'h0,                 12,64'h11223344_55667788, 1,0,8'h00,64'h0,                 0,1,64'h11223344_55667788};
        vecs[14] = '{"lw_sign", 64'h138,1,1,64'hD004, 5,0,64'h0,                 13,64'h80000000_00000000, 1,0,8'h00,64'h0,                 0,1,64'hFFFFFFFF_80000000};
        vecs[15] = '{"lh_mis",  64'h13C,1,1,64'hE001, 3,0,64'h0,                 14,64'h0,                 0,0,8'h00,64'h0,                 1,0,64'h0};

        // Reset state
        #3;
        chk("rst.dm_req", 64'(dm_req), 64'd0);
        chk("rst.mem_busy", 64'(mem_busy), 64'd0);
        chk("rst.pc_WB", pc_WB, 64'd0);
        chk("rst.rf_wr_en_WB", 64'(rf_wr_en_WB), 64'd0);
        chk("rst.misalign_WB", 64'(misalign_WB), 64'd0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // LD with dm_ready held low for 3 REQ cycles
        drive(64'h200, 1'b1, 2'd1, 64'h3000, 3'd7, 3'd0, 64'h0, 5'd9);
        dm_rdata = 64'h01020304_05060708;
        busy_cnt = 0; req_cnt = 0; writes = 0;
        for (int c = 0; c < 5; c++) begin
            dm_ready = (c == 4);
            @(negedge clk);
            if (dm_req) begin
                req_cnt++;
                chk("stall.dm_addr", dm_addr, 64'h3000);
            end
            if (mem_busy) busy_cnt++;
            @(posedge clk); #1;
            if (rf_wr_en_WB) writes++;
        end
        chk("stall.dm_data_WB", dm_data_WB, 64'h01020304_05060708);
        drive(64'h204, 1'b0, 2'd0, 64'h0, 3'd0, 3'd0, 64'h0, 5'd0);
        @(posedge clk); #1;
        if (rf_wr_en_WB) writes++;
        chk("stall.busy_cycles", 64'(busy_cnt), 64'd4);
        chk("stall.req_cycles", 64'(req_cnt), 64'd4);
        chk("stall.wb_writes", 64'(writes), 64'd1);
        $display("txn ld_stall busy=%0d writes=%0d", busy_cnt, writes);

        // Back-to-back ADD, LWU, ADD
        dm_ready = 1'b1;
        dm_rdata = 64'hDEADBEEF_00000000;
        drive(64'h10, 1'b1, 2'd0, 64'h5, 3'd0, 3'd0, 64'h0, 5'd1);
        @(posedge clk); #1;
        chk("b2b.add1_pc", pc_WB, 64'h10);
        chk("b2b.add1_we", 64'(rf_wr_en_WB), 64'd1);
        drive(64'h14, 1'b1, 2'd1, 64'h5004, 3'd6, 3'd0, 64'h0, 5'd2);
        @(posedge clk); #1;
        chk("b2b.bubble_we", 64'(rf_wr_en_WB), 64'd0);
        chk("b2b.bubble_mis", 64'(misalign_WB), 64'd0);
        @(posedge clk); #1;
        chk("b2b.lwu_we", 64'(rf_wr_en_WB), 64'd1);
        chk("b2b.lwu_rd", 64'(rd_WB), 64'd2);
        chk("b2b.lwu_data", dm_data_WB, 64'h00000000_DEADBEEF);
        drive(64'h18, 1'b1, 2'd0, 64'h7, 3'd0, 3'd0, 64'h0, 5'd3);
        @(posedge clk); #1;
        chk("b2b.add2_pc", pc_WB, 64'h18);
        chk("b2b.add2_we", 64'(rf_wr_en_WB), 64'd1);
        chk("b2b.add2_alu", alu_result_WB, 64'h7);
        $display("txn b2b_add_lwu_add done");

        // Reset asserted while a request is outstanding
        dm_ready = 1'b0;
        drive(64'h77, 1'b1, 2'd1, 64'h3000, 3'd7, 3'd0, 64'h0, 5'd4);
        @(posedge clk); #1;
        chk("rstreq.dm_req_before", 64'(dm_req), 64'd1);
        chk("rstreq.pc_before", pc_WB, 64'h77);
        #2 reset = 1'b0;
        #1;
        chk("rstreq.dm_req", 64'(dm_req), 64'd0);
        chk("rstreq.pc_WB", pc_WB, 64'd0);
        chk("rstreq.alu_WB", alu_result_WB, 64'd0);
        chk("rstreq.rd_WB", 64'(rd_WB), 64'd0);
        chk("rstreq.sel_WB", 64'(rf_wr_sel_WB), 64'd0);
        chk("rstreq.dm_data_WB", dm_data_WB, 64'd0);
        chk("rstreq.we_WB", 64'(rf_wr_en_WB), 64'd0);
        @(negedge clk); #1;
        reset = 1'b1;
        drive(64'h99, 1'b1, 2'd2, 64'h42, 3'd0, 3'd0, 64'h0, 5'd6);
        @(posedge clk); #1;
        chk("rstreq.first_pc", pc_WB, 64'h99);
        chk("rstreq.first_we", 64'(rf_wr_en_WB), 64'd1);
        chk("rstreq.first_dm_req", 64'(dm_req), 64'd0);
        $display("txn reset_in_req done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_stage7.md
PIPELINE_MEM_STAGE7 -- requirements
Module: pipeline_mem_stage7

Interface
REQ-001 SHALL have: clk  input  1  clock, rising-edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have EXC-side inputs: pc_EXC 64, rf_wr_en_EXC 1, rf_wr_sel_EXC 2, alu_result_EXC 64 (effective address or ALU value), dm_rd_ctrl_EXC 3, dm_wr_ctrl_EXC 3, reg_data2_EXC 64 (store data), rd_EXC 5.
REQ-004 SHALL have data-memory port: dm_req out 1, dm_we out 1, dm_addr out 64 (8-byte aligned), dm_wstrb out 8, dm_wdata out 64, dm_ready in 1, dm_rdata in 64.
REQ-005 SHALL have mem_busy out 1: stall request to all upstream stages, including the EXC stall input.
REQ-006 SHALL have WB-side outputs, all registered: pc_WB 64, rf_wr_en_WB 1, rf_wr_sel_WB 2, alu_result_WB 64, dm_data_WB 64, rd_WB 5, misalign_WB 1.

Function
REQ-007 dm_rd_ctrl encoding SHALL be: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD.
REQ-008 dm_wr_ctrl encoding SHALL be: 0 none, 1 SB, 2 SH, 3 SW, 4 SD; values 5-7 SHALL be treated as none.
REQ-009 A memory op (mem_op) SHALL be any nonzero read or valid write control; if both are nonzero, the write SHALL win.
REQ-010 Misaligned SHALL be true when addr[0]≠0 for H, addr[1:0]≠0 for W, or addr[2:0]≠0 for D; byte accesses are never misaligned.
REQ-011 FSM states SHALL be IDLE and REQ.
REQ-012 IDLE, aligned mem_op: mem_busy=1 combinationally; next state REQ.
REQ-013 REQ: dm_req=1 and all dm_* outputs held stable; mem_busy=~dm_ready; on dm_ready=1, next state IDLE and the WB registers capture.
REQ-014 dm_addr SHALL be {addr[63:3],3'b000}; dm_we=1 for stores.
REQ-015 dm_wstrb SHALL be the size mask (8'h01/03/0F/FF) shifted left by addr[2:0].
REQ-016 dm_wdata SHALL be reg_data2 low bytes replicated into every lane of the access size.
REQ-017 Load data SHALL be dm_rdata shifted right by addr[2:0]*8, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to 64 bits.
REQ-018 Non-mem ops and misaligned ops SHALL complete in 1 cycle: mem_busy=0, no dm_req, WB registers capture at the next edge.
REQ-019 A misaligned op SHALL set misalign_WB=1 and force rf_wr_en_WB=0; otherwise misalign_WB=0.
REQ-020 WB capture SHALL forward pc, rf_wr_en, rf_wr_sel, alu_result and rd unchanged; dm_data_WB SHALL hold the extended load data for loads and 0 otherwise.
REQ-021 Stores SHALL forward rf_wr_en unchanged; the decoder guarantees it is 0.
REQ-022 While mem_busy=1, the WB registers SHALL capture a bubble (rf_wr_en_WB=0, misalign_WB=0) so that no write-back repeats.
REQ-023 dm_ready SHALL be ignored in IDLE.
REQ-024 Load latency SHALL be 2 cycles minimum (1 IDLE + 1 REQ), plus 1 cycle per dm_ready=0 cycle in REQ.

Reset
REQ-025 On reset=0: state=IDLE and all WB outputs=0, regardless of any in-flight request; combinational outputs SHALL evaluate from IDLE (dm_req=0).
REQ-026 Reset deassertion SHALL be synchronized externally; the first operation SHALL be accepted on the first edge after release.

Structure
REQ-027 Package pipeline_mem_pkg SHALL hold the rd/wr control encodings, size masks and the state enum.
REQ-028 Sub-module mem_lsu_align (combinational) SHALL implement misalign detect, wstrb/wdata build and load extract/extend; the FSM and registers SHALL stay in the top module.
REQ-029 No memory array SHALL be instantiated inside this block.

Verification
REQ-030 LB at addr 0x1003, dm_rdata=0x00000000_80000000, dm_ready in the first REQ cycle -> dm_addr=0x1000, dm_data_WB=0xFFFF_FFFF_FFFF_FF80, mem_busy high for exactly 1 cycle.
REQ-031 SH at addr 0x2006, reg_data2=0x1234 -> dm_wstrb=8'hC0, dm_wdata[63:48]=0x1234, dm_we=1.
REQ-032 LD at 0x3000 with dm_ready held low 3 REQ cycles -> dm_req and dm_addr stable throughout, mem_busy high 4 cycles, a single WB write.
REQ-033 LW at 0x4002 -> no dm_req, misalign_WB=1, rf_wr_en_WB=0, mem_busy stays 0.
REQ-034 Back-to-back ADD, LWU 0x5004 (rdata=0xDEADBEEF_00000000), ADD -> WB sequence ADD, bubble, LWU data=0x0000_0000_DEAD_BEEF, ADD.
REQ-035 Reset asserted while in REQ with dm_ready=0 -> dm_req drops immediately, all WB outputs=0, state=IDLE.
